// File: rtl/cpu_multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// ALU_ADD is also consumed by the ALU.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    ERROR
  } state_t;

  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [1:0] OP_DP   = 2'b00;
  localparam logic [3:0] ALU_ADD = 4'b0000;

  typedef struct packed {
    logic is_al;
    logic is_legal_add;
    logic imm_sel;
    logic set_flags;
  } dec_t;

endpackage

// File: rtl/cpu_multicycle_ctrl_if.sv
// Control/instruction bus between the sequencer and the datapath.
// master = control unit, slave = datapath / instruction memory.
interface cpu_multicycle_ctrl_if;
  logic [31:0] instr;
  logic        imem_ack;
  logic        imem_req;
  logic        ir_en;
  logic        pc_en;
  logic        reg_we;
  logic        alu_src_imm;
  logic [3:0]  alu_control;
  logic        flags_we;

  modport master (
    input  instr, imem_ack,
    output imem_req, ir_en, pc_en, reg_we,
    output alu_src_imm, alu_control, flags_we
  );

  modport slave (
    output instr, imem_ack,
    input  imem_req, ir_en, pc_en, reg_we,
    input  alu_src_imm, alu_control, flags_we
  );
endinterface

// File: rtl/cpu_multicycle_ctrl_decoder.sv
// Field decode of the instruction register for the ADD sequencer.
// Condition is checked separately so non-AL words can be skipped.
module cpu_ctrl_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic unused_bits;
  assign unused_bits = ^{instr[19:16], instr[11:0]};

  always_comb begin
    dec              = '0;
    dec.is_al        = (instr[31:28] == COND_AL);
    dec.is_legal_add = (instr[27:26] == OP_DP)
                    && (instr[24:21] == CMD_ADD)
                    && (instr[15:12] != 4'hF);
    dec.imm_sel      = instr[25];
    dec.set_flags    = instr[20];
  end

endmodule

// File: rtl/cpu_multicycle_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXECUTE/WRITEBACK for ADD,
// with fetch timeout and sticky trap on unsupported encodings.
module cpu_multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int RETIRE_W    = 16,
  parameter int ACK_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  cpu_multicycle_ctrl_if.master bus,
  output logic                busy,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  state_t            state, nxt;
  logic [TMO_W-1:0]  wait_cnt;
  logic              stop_pending;
  logic              imm_q;
  logic              s_q;
  dec_t              dec;

  cpu_ctrl_decoder u_dec (
    .instr (bus.instr),
    .dec   (dec)
  );

  always_comb begin
    nxt             = state;
    bus.imem_req    = 1'b0;
    bus.ir_en       = 1'b0;
    bus.pc_en       = 1'b0;
    bus.reg_we      = 1'b0;
    bus.alu_src_imm = 1'b0;
    bus.alu_control = 4'b0000;
    bus.flags_we    = 1'b0;
    busy            = 1'b0;
    illegal         = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) nxt = FETCH;
      end
      FETCH: begin
        busy         = 1'b1;
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          bus.ir_en = 1'b1;
          nxt       = DECODE;
        end else if (wait_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
          nxt = ERROR;
        end
      end
      DECODE: begin
        busy = 1'b1;
        if (!dec.is_al) begin
          bus.pc_en = 1'b1;
          nxt       = stop_pending ? IDLE : FETCH;
        end else if (!dec.is_legal_add) begin
          nxt = ERROR;
        end else begin
          nxt = EXECUTE;
        end
      end
      EXECUTE: begin
        busy            = 1'b1;
        bus.alu_src_imm = imm_q;
        bus.alu_control = ALU_ADD;
        nxt             = WRITEBACK;
      end
      WRITEBACK: begin
        busy            = 1'b1;
        bus.alu_src_imm = imm_q;
        bus.alu_control = ALU_ADD;
        bus.reg_we      = 1'b1;
        bus.flags_we    = s_q;
        bus.pc_en       = 1'b1;
        nxt             = (stop_pending || stop) ? IDLE : FETCH;
      end
      ERROR: begin
        illegal = 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      stop_pending <= 1'b0;
      imm_q        <= 1'b0;
      s_q          <= 1'b0;
      retired      <= '0;
    end else begin
      state <= nxt;
      if (state == FETCH)
        wait_cnt <= bus.imem_ack ? '0 : wait_cnt + 1'b1;
      if (state == DECODE) begin
        imm_q <= dec.imm_sel;
        s_q   <= dec.set_flags;
      end
      // leaving for IDLE always clears, even if stop is seen that cycle
      if (state != IDLE && nxt == IDLE)
        stop_pending <= 1'b0;
      else if (busy && stop)
        stop_pending <= 1'b1;
      if (state == WRITEBACK)
        retired <= retired + 1'b1;
    end
  end

endmodule

// File: doc/cpu_multicycle_ctrl.md
Name: cpu_multicycle_ctrl

Overview:
Multi-cycle control unit for the single-issue CPU datapath: program counter, instruction memory, structural register file and ALU. It sequences fetch/decode/execute/writeback for the ARM-style data-processing ADD (register) and ADD (immediate) instructions. It drives the enables that currently sit hard-wired in the top level (PC update, IR latch, WE3, ALU source select, ALU control). It traps unsupported encodings and instruction-memory stalls into a sticky error state.

Parameters:
RETIRE_W, 16, width of retired-instruction counter
ACK_TIMEOUT, 15, max cycles FETCH waits for imem_ack before trapping (must be >= 1)
TMO_W, 4, width of fetch wait counter; must hold ACK_TIMEOUT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset (reset==0 at a rising clk edge resets the block)
start  in  1  begin executing from the current PC (sampled in IDLE only)
stop  in  1  request halt after the in-flight instruction retires
instr  in  32  instruction register contents (valid from DECODE onward)
imem_ack  in  1  instruction memory data valid
imem_req  out  1  fetch request to instruction memory
ir_en  out  1  latch instruction register
pc_en  out  1  advance PC (PC+4 computed in the datapath)
reg_we  out  1  register file WE3
alu_src_imm  out  1  0 = SrcB from RD2, 1 = zero-extended imm8 from instr[7:0]
alu_control  out  4  ALU operation code
flags_we  out  1  update NZCV flags register
busy  out  1  high in FETCH/DECODE/EXECUTE/WRITEBACK
illegal  out  1  sticky error indication
retired  out  RETIRE_W  count of retired ADD instructions

Behaviour:
- Reset values: all 1-bit outputs 0, alu_control=4'b0000, retired=0. State=IDLE, stop_pending=0, wait counter=0.
- Reset has priority over every other input in every state. An in-flight instruction is discarded: no reg_we, no pc_en.
- Decode fields: cond=instr[31:28], op=instr[27:26], I=instr[25], cmd=instr[24:21], S=instr[20], Rd=instr[15:12].
- I and S are latched in DECODE into an internal register and used in EXECUTE/WRITEBACK.
- IDLE: start=1 -> FETCH. stop in IDLE is ignored. If start and stop are both asserted, start wins and stop is not recorded.
- FETCH: imem_req=1.
  - imem_ack=1 -> ir_en=1 in the same cycle, wait counter cleared, -> DECODE.
  - imem_ack=0 -> counter increments. When the counter reaches ACK_TIMEOUT with ack still 0 -> ERROR.
- DECODE: no outputs asserted.
  - cond!=4'b1110 (not AL) -> skip: pc_en=1 for one cycle, retired unchanged, -> FETCH, or -> IDLE if stop_pending.
  - op!=2'b00, or cmd!=4'b0100, or Rd==4'hF -> ERROR.
  - otherwise -> EXECUTE.
- EXECUTE: alu_control=4'b0000 (ADD), alu_src_imm=latched I. -> WRITEBACK.
- WRITEBACK: alu_control and alu_src_imm held at their EXECUTE values. reg_we=1, flags_we=latched S, pc_en=1, retired increments (wraps modulo 2^RETIRE_W). -> IDLE if stop_pending or stop, else -> FETCH. stop_pending is cleared on entering IDLE.
- stop asserted in any busy state sets stop_pending. Halt occurs only at an instruction boundary: WRITEBACK exit or DECODE skip.
- ERROR: illegal=1, busy=0, all enables 0. start and stop are ignored. Exit only by reset.
- Latency: 4 cycles per retired ADD with zero-wait ack (FETCH, DECODE, EXECUTE, WRITEBACK). 2 cycles per skipped instruction. Each wait cycle adds 1.
- Single-cycle pulses: reg_we, pc_en, ir_en and flags_we never stay high for more than 1 consecutive cycle.
- Outputs are Moore-style decode of state plus latched I/S; ir_en and imem_req are the only outputs dependent on imem_ack/state in FETCH.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, ERROR
  - COND_AL=4'b1110, CMD_ADD=4'b0100, OP_DP=2'b00
  - ALU_ADD=4'b0000, shared with the ALU
- One combinational sub-module, cpu_ctrl_decoder: instr -> {is_al, is_legal_add, imm_sel, set_flags}.
- The FSM, wait counter, stop_pending and retired counter live in cpu_multicycle_ctrl.

Test Plan:
- Reset low 2 cycles, start=1, instr=0xE0812003 (ADD R2,R1,R3), imem_ack=1 -> ir_en in cycle 1; reg_we=1, alu_src_imm=0, flags_we=0, pc_en=1 in cycle 4; retired=1.
- instr=0xE2912005 (ADDS R2,R1,#5) -> alu_src_imm=1 in EXECUTE and WRITEBACK, flags_we=1 in WRITEBACK. Back-to-back run of 3 gives retired=3 after 12 cycles.
- instr=0x00812003 (ADDEQ) -> DECODE asserts pc_en only; reg_we never asserted; retired unchanged; next FETCH 2 cycles after start.
- instr=0xE0412003 (SUB) or 0xE081F003 (Rd=PC) -> ERROR next cycle, illegal=1 held for 20 cycles despite start pulses; cleared by reset=0.
- imem_ack held 0 with ACK_TIMEOUT=15 -> illegal=1 after 15 FETCH cycles. Second run with ack arriving at wait cycle 14 -> normal retire, no trap.
- stop pulsed in EXECUTE -> WRITEBACK completes (reg_we=1), then IDLE, busy=0. Reset=0 asserted in EXECUTE -> no reg_we, retired unchanged, IDLE next cycle.
